// File: rtl/clock_time_setter.sv
// HH:MM:SS time-keeping and key-driven time-setting controller.
// Optional field blinking in set mode is enabled by defining DIGITALCLOCK_BLINK_EN.
module clock_time_setter #(
   parameter int BLINK_DIV = 25_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic       key_mode,
   input  logic       key_inc,
   input  logic       key_dec,
   output logic [4:0] hh,
   output logic [5:0] mm,
   output logic [5:0] ss,
   output logic       set_mode,
   output logic [1:0] sel,
   output logic [2:0] blank
);

   // state  | meaning
   // RUN    | time advances on tick_1hz, INC/DEC ignored
   // SET_HH | time frozen, INC/DEC adjust hours
   // SET_MM | time frozen, INC/DEC adjust minutes
   // SET_SS | time frozen, INC/DEC adjust seconds
   typedef enum logic [1:0] {RUN = 2'd0, SET_HH = 2'd1, SET_MM = 2'd2, SET_SS = 2'd3} state_t;

   state_t     state_q, state_d;
   logic [4:0] hh_q, hh_d;
   logic [5:0] mm_q, mm_d;
   logic [5:0] ss_q, ss_d;
   logic [2:0] prev_q;
   logic       set_mode_q;
   logic [2:0] blank_q, blank_d;

   logic press_mode, press_inc, press_dec, adj_up, adj_dn;

   if (BLINK_DIV < 2) begin : g_div_chk
      $error("BLINK_DIV must be at least 2");
   end

   assign press_mode = prev_q[2] & ~key_mode;
   assign press_inc  = prev_q[1] & ~key_inc;
   assign press_dec  = prev_q[0] & ~key_dec;
   assign adj_up     = press_inc & ~press_dec;
   assign adj_dn     = press_dec & ~press_inc;

   always_comb begin
      state_d = state_q;
      hh_d    = hh_q;
      mm_d    = mm_q;
      ss_d    = ss_q;
      // A tick in RUN is honoured even when MODE is pressed in the same cycle.
      if (state_q == RUN && tick_1hz) begin
         if (ss_q == 6'd59) begin
            ss_d = 6'd0;
            if (mm_q == 6'd59) begin
               mm_d = 6'd0;
               hh_d = (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
            end else begin
               mm_d = mm_q + 6'd1;
            end
         end else begin
            ss_d = ss_q + 6'd1;
         end
      end
      if (press_mode) begin
         state_d = state_t'(state_q + 2'd1);
      end else begin
         case (state_q)
            SET_HH: begin
               if (adj_up)      hh_d = (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
               else if (adj_dn) hh_d = (hh_q == 5'd0) ? 5'd23 : hh_q - 5'd1;
            end
            SET_MM: begin
               if (adj_up)      mm_d = (mm_q == 6'd59) ? 6'd0 : mm_q + 6'd1;
               else if (adj_dn) mm_d = (mm_q == 6'd0) ? 6'd59 : mm_q - 6'd1;
            end
            SET_SS: begin
               if (adj_up)      ss_d = (ss_q == 6'd59) ? 6'd0 : ss_q + 6'd1;
               else if (adj_dn) ss_d = (ss_q == 6'd0) ? 6'd59 : ss_q - 6'd1;
            end
            default: ;
         endcase
      end
   end

`ifdef DIGITALCLOCK_BLINK_EN
   localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          phase_q, phase_d;
   logic          press_any;

   assign press_any = press_mode | press_inc | press_dec;

   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      // Restart with the field visible whenever the user interacts.
      if (press_any || state_d != state_q) begin
         cnt_d   = '0;
         phase_d = 1'b0;
      end else if (cnt_q == CW'(BLINK_DIV - 1)) begin
         cnt_d   = '0;
         phase_d = ~phase_q;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
      case (state_d)
         SET_HH:  blank_d = {phase_d, 2'b00};
         SET_MM:  blank_d = {1'b0, phase_d, 1'b0};
         SET_SS:  blank_d = {2'b00, phase_d};
         default: blank_d = 3'b000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end
`else
   assign blank_d = 3'b000;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RUN;
         hh_q       <= 5'd0;
         mm_q       <= 6'd0;
         ss_q       <= 6'd0;
         prev_q     <= 3'b111;
         set_mode_q <= 1'b0;
         blank_q    <= 3'b000;
      end else begin
         state_q    <= state_d;
         hh_q       <= hh_d;
         mm_q       <= mm_d;
         ss_q       <= ss_d;
         prev_q     <= {key_mode, key_inc, key_dec};
         set_mode_q <= (state_d != RUN);
         blank_q    <= blank_d;
      end
   end

   assign hh       = hh_q;
   assign mm       = mm_q;
   assign ss       = ss_q;
   assign sel      = state_q;
   assign set_mode = set_mode_q;
   assign blank    = blank_q;

endmodule
